// File: rtl/attention_softmax.sv
// attention_softmax: row-wise softmax over Q1.15 attention scores.
// Each row is processed in turn: MAX (row max), EXP (LUT exponent and sum),
// DIV (serial reciprocal floor(2^31/S)), then NORM (P = e*r >> 16, saturated).
// Optional build macro SOFTMAX_CAUSAL_MASK_EN: element j of row r is masked when
// j > r/N. Masked elements are left out of the max and the sum, and their P is 0.
//
// state | meaning
// IDLE  | waiting for start; A_in is captured on the accept cycle
// MAX   | one element per cycle, running signed max of the row
// EXP   | one element per cycle, e = LUT[(m-x)>>10], accumulate S
// DIV   | 32 cycles of restoring division, one quotient bit per cycle
// NORM  | one element per cycle, P = sat((e*r)>>16) written to P_out
// DONE  | one cycle, done/out_valid pulse
module attention_softmax #(
    parameter int DATA_WIDTH = 16,
    parameter int L          = 8,
    parameter int N          = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    output logic                         busy,
    input  logic [DATA_WIDTH*L*N*L-1:0]  A_in,
    output logic [DATA_WIDTH*L*N*L-1:0]  P_out,
    output logic                         done,
    output logic                         out_valid
);

    localparam int R  = L * N;
    localparam int JW = (L > 1) ? $clog2(L) : 1;
    localparam int RW = (R > 1) ? $clog2(R) : 1;
    localparam int SW = DATA_WIDTH + $clog2(L) + 1;

    // exp(-k/32) in Q0.15, rounded, clipped to 32767
    localparam logic [15:0] EXP_LUT [64] = '{
        16'd32767, 16'd31760, 16'd30783, 16'd29836, 16'd28918, 16'd28028, 16'd27166, 16'd26330,
        16'd25520, 16'd24735, 16'd23974, 16'd23236, 16'd22521, 16'd21828, 16'd21157, 16'd20506,
        16'd19875, 16'd19263, 16'd18671, 16'd18096, 16'd17539, 16'd17000, 16'd16477, 16'd15970,
        16'd15479, 16'd15002, 16'd14541, 16'd14093, 16'd13660, 16'd13239, 16'd12832, 16'd12437,
        16'd12055, 16'd11684, 16'd11324, 16'd10976, 16'd10638, 16'd10311, 16'd9994,  16'd9686,
        16'd9388,  16'd9099,  16'd8819,  16'd8548,  16'd8285,  16'd8030,  16'd7783,  16'd7544,
        16'd7312,  16'd7087,  16'd6869,  16'd6657,  16'd6452,  16'd6254,  16'd6061,  16'd5875,
        16'd5694,  16'd5519,  16'd5349,  16'd5185,  16'd5025,  16'd4871,  16'd4721,  16'd4575
    };

    typedef enum logic [2:0] {
        S_IDLE, S_MAX, S_EXP, S_DIV, S_NORM, S_DONE
    } state_t;

    state_t                        state;
    logic signed [DATA_WIDTH-1:0]  a_buf [R][L];
    logic [DATA_WIDTH-1:0]         e_buf [L];
    logic [DATA_WIDTH-1:0]         p_mem [R][L];
    logic signed [DATA_WIDTH-1:0]  m_max;
    logic [SW-1:0]                 s_acc;
    logic [SW-1:0]                 rem;
    logic [31:0]                   quo;
    logic [4:0]                    div_cnt;
    logic [JW-1:0]                 col;
    logic [RW-1:0]                 row;

    logic signed [DATA_WIDTH-1:0]  x_cur;
    logic signed [DATA_WIDTH:0]    diff;
    logic [DATA_WIDTH:0]           neg_diff;
    logic [5:0]                    lut_idx;
    logic [DATA_WIDTH-1:0]         e_cur;
    logic                          masked;
    logic [SW:0]                   trial;
    logic [SW:0]                   trial_sub;
    logic                          q_bit;
    logic [32:0]                   prod;
    logic [16:0]                   norm;
    logic [DATA_WIDTH-1:0]         p_cur;
    logic                          col_last;
    logic                          row_last;

    // Per-element datapath: exponent lookup, divider step, normalisation
    always_comb begin
        x_cur    = a_buf[row][col];
        // 17-bit difference so 0x8000 against 0x7FFF cannot overflow
        diff     = {x_cur[DATA_WIDTH-1], x_cur} - {m_max[DATA_WIDTH-1], m_max};
        neg_diff = -diff;
        lut_idx  = 6'(neg_diff >> 10);
`ifdef SOFTMAX_CAUSAL_MASK_EN
        masked   = int'(col) > (int'(row) / N);
`else
        masked   = 1'b0;
`endif
        e_cur     = masked ? '0 : EXP_LUT[lut_idx];
        // First divider step shifts in the single set dividend bit (2^31)
        trial     = {rem, (div_cnt == 5'd0)};
        trial_sub = trial - {1'b0, s_acc};
        q_bit     = (trial >= {1'b0, s_acc});
        prod      = 33'(e_buf[col]) * 33'(17'(quo));
        norm      = 17'(prod >> 16);
        if (masked)
            p_cur = '0;
        else if (norm > 17'h07FFF)
            p_cur = 16'h7FFF;
        else
            p_cur = 16'(norm);
        col_last  = (col == JW'(L - 1));
        row_last  = (row == RW'(R - 1));
    end

    // Sequencing FSM with registered busy/done/out_valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            m_max     <= '0;
            s_acc     <= '0;
            rem       <= '0;
            quo       <= '0;
            div_cnt   <= '0;
            col       <= '0;
            row       <= '0;
            for (int r = 0; r < R; r++) begin
                for (int j = 0; j < L; j++) begin
                    a_buf[r][j] <= '0;
                    p_mem[r][j] <= '0;
                end
            end
            for (int j = 0; j < L; j++)
                e_buf[j] <= '0;
        end else begin
            done      <= 1'b0;
            out_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        for (int r = 0; r < R; r++)
                            for (int j = 0; j < L; j++)
                                a_buf[r][j] <= A_in[(r*L + j)*DATA_WIDTH +: DATA_WIDTH];
                        busy  <= 1'b1;
                        row   <= '0;
                        col   <= '0;
                        state <= S_MAX;
                    end
                end
                S_MAX: begin
                    // Element 0 is never masked, so it always seeds the max
                    if (col == '0 || (!masked && x_cur > m_max))
                        m_max <= x_cur;
                    if (col_last) begin
                        col   <= '0;
                        state <= S_EXP;
                    end else begin
                        col <= col + 1'b1;
                    end
                end
                S_EXP: begin
                    e_buf[col] <= e_cur;
                    s_acc      <= (col == '0) ? SW'(e_cur) : s_acc + SW'(e_cur);
                    if (col_last) begin
                        col     <= '0;
                        rem     <= '0;
                        quo     <= '0;
                        div_cnt <= '0;
                        state   <= S_DIV;
                    end else begin
                        col <= col + 1'b1;
                    end
                end
                S_DIV: begin
                    rem     <= q_bit ? SW'(trial_sub) : SW'(trial);
                    quo     <= {quo[30:0], q_bit};
                    div_cnt <= div_cnt + 5'd1;
                    if (div_cnt == 5'd31)
                        state <= S_NORM;
                end
                S_NORM: begin
                    p_mem[row][col] <= p_cur;
                    if (col_last) begin
                        col <= '0;
                        if (row_last) begin
                            done      <= 1'b1;
                            out_valid <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            row   <= row + 1'b1;
                            state <= S_MAX;
                        end
                    end else begin
                        col <= col + 1'b1;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    for (genvar gr = 0; gr < R; gr++) begin : g_row
        for (genvar gj = 0; gj < L; gj++) begin : g_col
            assign P_out[(gr*L + gj)*DATA_WIDTH +: DATA_WIDTH] = p_mem[gr][gj];
        end
    end

endmodule
